// File: rtl/merge_imag.sv
// merge_imag: reassembles FILTER_SIZE x FILTER_SIZE tiles into a SIZE x SIZE image.
// Optional MERGE_IMAG_TILE_IDX_EN adds tile_idx placement and sticky idx_err.
module merge_imag #(
  parameter int SIZE        = 9,
  parameter int FILTER_SIZE = 3,
  parameter int DATA_W      = 32,
  localparam int TPR        = SIZE / FILTER_SIZE,
  localparam int NUM_TILES  = TPR * TPR,
  localparam int CW         = $clog2(NUM_TILES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_W-1:0] tile_in,
  input  logic tile_valid,
  output logic tile_ready,
  output logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] image_out,
  output logic image_valid,
  input  logic image_ready,
`ifdef MERGE_IMAG_TILE_IDX_EN
  input  logic [CW-1:0] tile_idx,
  output logic idx_err,
`endif
  output logic [CW-1:0] tiles_done
);

  typedef enum logic {FILL, FULL} state_e;

  localparam logic [CW-1:0] LAST_T = CW'(NUM_TILES - 1);
  localparam logic [CW-1:0] N_T    = CW'(NUM_TILES);
  localparam int            COVER  = TPR * FILTER_SIZE;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] dest;
  logic          accept;
  logic          idx_ok;
  logic          wr;

  assign tile_ready  = en && (state_q == FILL);
  assign accept      = tile_valid && tile_ready;
  assign image_valid = (state_q == FULL);
  assign tiles_done  = cnt_q;

`ifdef MERGE_IMAG_TILE_IDX_EN
  logic idx_err_q, idx_err_d;

  assign dest      = tile_idx;
  assign idx_ok    = (tile_idx < N_T);
  assign idx_err_d = idx_err_q || (accept && !idx_ok);
  assign idx_err   = idx_err_q;

  // Out-of-range index flag stays set until reset
  always_ff @(posedge clk) begin
    if (reset) idx_err_q <= 1'b0;
    else       idx_err_q <= idx_err_d;
  end
`else
  assign dest   = cnt_q;
  assign idx_ok = 1'b1;
`endif

  assign wr = accept && idx_ok;

  // Count written tiles; hand the image off on the output handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (wr) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_T) state_d = FULL;
        end
      end
      FULL: begin
        if (image_ready) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  // State and tile counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      if (r < COVER && c < COVER) begin : g_px
        localparam int TI = r % FILTER_SIZE;
        localparam int TJ = c % FILTER_SIZE;
        localparam logic [CW-1:0] TID =
          CW'((r / FILTER_SIZE) * TPR + c / FILTER_SIZE);
        logic [DATA_W-1:0] px_q;
        // Capture this pixel when its owning tile is written
        always_ff @(posedge clk) begin
          if (reset)
            px_q <= '0;
          else if (wr && dest == TID)
            px_q <= tile_in[TI][TJ];
        end
        assign image_out[r][c] = px_q;
      end else begin : g_pad
        assign image_out[r][c] = '0;
      end
    end
  end

endmodule

// File: doc/merge_imag.md
MERGE_IMAG -- requirements
Module: merge_imag

Interface
REQ-001 SHALL have parameter SIZE, default 9, meaning image edge length in pixels.
REQ-002 SHALL have parameter FILTER_SIZE, default 3, meaning tile edge length in pixels.
REQ-003 SHALL have parameter DATA_W, default 32, meaning pixel width in bits.
REQ-004 SHALL use derived constants: TPR = SIZE/FILTER_SIZE (tiles per row), NUM_TILES = TPR*TPR, CW = $clog2(NUM_TILES+1).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  global enable; low stalls tile acceptance.
REQ-008 SHALL have port tile_in  input  DATA_W x [FILTER_SIZE][FILTER_SIZE]  one complete tile per beat.
REQ-009 SHALL have port tile_valid  input  1  tile_in is valid.
REQ-010 SHALL have port tile_ready  output  1  block accepts a tile this cycle.
REQ-011 SHALL have port image_out  output  DATA_W x [SIZE][SIZE]  reassembled image, registered.
REQ-012 SHALL have port image_valid  output  1  image_out is complete.
REQ-013 SHALL have port image_ready  input  1  consumer takes the image.
REQ-014 SHALL have port tiles_done  output  CW  number of tiles accepted into the current image.

Function
REQ-015 SHALL implement two states: FILL and FULL.
REQ-016 SHALL drive tile_ready = en AND (state == FILL), combinationally.
REQ-017 SHALL accept a tile on a rising edge where tile_valid, tile_ready are both high.
REQ-018 SHALL place accepted tile t (raster order, t = tiles_done) at image_out[(t/TPR)*FILTER_SIZE + i][(t%TPR)*FILTER_SIZE + j] = tile_in[i][j], visible one cycle after acceptance.
REQ-019 SHALL increment tiles_done by 1 per accepted tile.
REQ-020 SHALL move FILL->FULL on the edge accepting tile NUM_TILES-1; image_valid rises the same edge, with the last tile already in image_out.
REQ-021 SHALL hold image_out, image_valid=1, tiles_done=NUM_TILES in FULL until image_valid AND image_ready.
REQ-022 SHALL, on that handshake edge, go to FILL, clear image_valid and tiles_done; image_out contents are retained until overwritten.
REQ-023 SHALL ignore tile_valid while in FULL or en low (no write, no count change).
REQ-024 SHALL leave pixels outside the TPR*FILTER_SIZE region (SIZE not a multiple of FILTER_SIZE) at zero permanently.
REQ-025 SHALL not change state on image_ready while in FILL.

Reset
REQ-026 SHALL, on reset high at a rising edge, force state FILL, tiles_done 0, image_valid 0, all image_out pixels 0.
REQ-027 SHALL let reset override any simultaneous tile or image handshake, discarding partial images mid-operation.

Configuration
REQ-028 SHALL support macro MERGE_IMAG_TILE_IDX_EN.
REQ-029 With MERGE_IMAG_TILE_IDX_EN defined, SHALL add input tile_idx (CW bits) selecting the destination tile instead of raster order, plus output idx_err (1 bit).
REQ-030 With it defined, tile_idx >= NUM_TILES SHALL be accepted but not written or counted, and SHALL set idx_err sticky until reset.
REQ-031 With it defined, duplicate indices SHALL overwrite and count; FULL is entered after NUM_TILES valid-index acceptances.
REQ-032 Without the macro, tile_idx and idx_err SHALL not exist and placement SHALL be raster order.

Verification
REQ-033 SIZE=9, FILTER_SIZE=3, en=1, image_ready=0, tiles 0..8 each filled with constant t+1 back-to-back -> image_valid high one cycle after 9th accept, image_out[4][7]=6, image_out[8][8]=9, tiles_done=9.
REQ-034 FULL held with image_ready=0 for 5 cycles while tile_valid=1 -> tile_ready=0, image_out unchanged; image_ready=1 -> next cycle image_valid=0, tiles_done=0, tile_ready=1.
REQ-035 en=0 for 3 cycles after 4 tiles with tile_valid=1 -> tiles_done stays 4; en=1 resumes at tile 4 (rows 3..5, cols 3..5).
REQ-036 reset pulsed after 4 accepted tiles -> next cycle tiles_done=0, image_valid=0, all 81 pixels 0.
REQ-037 SIZE=10, FILTER_SIZE=3, tiles all 7 -> row 9 and column 9 read 0, others 7.
REQ-038 MERGE_IMAG_TILE_IDX_EN defined, tile_idx=9 -> idx_err=1, tiles_done unchanged; tiles 8 down to 0 then fill image identically to REQ-033.
